data_memory_wait: RTL
=====================

Name: data_memory_wait

Overview:
- Parametrised byte-addressable data memory for the MEM stage of the pipelined CPU. Next generation of the single-cycle data memory.
- Adds byte, half and word accesses with sign/zero extension, little-endian byte lanes and alignment/range checking.
- Adds a configurable wait-state FSM that stalls the pipeline, so slow memory can be modelled.
- Exposes a debug byte for the testbench.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes (power of two, >=4).
- WAIT_CYCLES, 2, extra cycles between request acceptance and completion (0..15).
- DBG_ADDR, 0, byte address driven on memory_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_i  in  1  access request (MemRead or MemWrite from the pipeline)
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- signed_i  in  1  sign-extend byte/half loads
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data; low bytes are used for byte/half
- rdata_o  out  32  load result, registered
- ack_o  out  1  one-cycle completion pulse
- stall_o  out  1  freeze the pipeline
- err_o  out  1  error flag, valid with ack_o
- memory_o  out  8  memory[DBG_ADDR], combinational

Behaviour:
- Interface:
  - One clock, clk_i. Reset rst_i is synchronous and active-high.
  - Reset sets state IDLE, wait counter 0, rdata_o=0, ack_o=0, err_o=0 and all memory bytes 0. stall_o=0 after reset unless req_i=1.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, req_i=1: latch we/size/signed/addr/wdata. If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1; else go to DONE.
  - WAIT: decrement counter; at 0, go to DONE.
  - DONE: ack_o=1 for exactly this cycle, then IDLE unconditionally.
  - req_i is ignored outside IDLE. Back-to-back accesses therefore have at least one IDLE cycle between acks.
  - Latency: ack_o rises WAIT_CYCLES+1 cycles after the edge that samples req_i.
- stall_o = (state==IDLE && req_i) || state==WAIT. This is combinational and low in DONE, so the pipeline advances on the ack cycle.
  - The pipeline holds req/addr stable while stall_o=1. The block uses only its latched copy.
- Commit: on the edge entering DONE.
  - A store writes bytes addr..addr+N-1, little-endian: byte 0 = wdata[7:0].
  - A load captures rdata_o on the same edge. rdata_o holds its value until the next load completes; stores leave it unchanged.
- Load formatting:
  - byte: mem[a], extended per signed_i.
  - half: {mem[a+1],mem[a]}, extended per signed_i.
  - word: {mem[a+3..a]}.
- Errors, computed at latch time and reported with ack_o: err_o=1 on any of
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size_i=11;
  - addr+N-1 >= DEPTH_BYTES.
  - On error, a store writes nothing and a load sets rdata_o=0.
  - The request still completes with normal latency and normal stall behaviour.
- Reset mid-operation (WAIT or DONE): FSM returns to IDLE, the pending store is dropped, no ack is produced and memory is cleared.
- Address decode compares the full 32 bits. Addresses do not wrap.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state enum;
  - function bytes_of(size).
- Sub-module dmem_align, combinational:
  - produces the store byte-enable/lane data and the load extract/extension from size, signed, addr[1:0] and err.
  - It is instantiated once. The FSM, counter and array live in data_memory_wait.

Test Plan (WAIT_CYCLES=2 unless noted):
- Store then load:
  - stimulus: sw addr 0x8 data 0xDEADBEEF, then lw 0x8.
  - response: stall_o high 3 cycles, ack at cycle+3, bytes 8..11 = EF BE AD DE, rdata_o=0xDEADBEEF, err_o=0.
- Sign/zero extension on the same data:
  - lb signed 0x9 -> 0xFFFFFFBE; lbu 0x9 -> 0x000000BE.
  - lh signed 0xA -> 0xFFFFDEAD; lhu 0xA -> 0x0000DEAD.
- Misaligned and reserved size:
  - sh 0x3, lw 0x6, size 11 -> each acks with err_o=1; memory unchanged; loads give rdata_o=0.
- Debug byte and range:
  - sb 0x0 data 0x1234565A -> memory_o=0x5A.
  - lw addr DEPTH_BYTES-2 -> err_o=1, rdata_o=0.
- Reset mid-access:
  - sw 0x10 data 0x11223344, rst_i asserted in WAIT -> no ack_o, stall_o=0 next cycle.
  - A subsequent lw 0x10 returns 0.
- WAIT_CYCLES=0 instance:
  - req sampled -> ack next cycle with stall_o high one cycle.
  - A back-to-back req held high -> second ack two cycles after the first.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory: access size encodings,
// controller states and the byte count of each access size.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int CNT_W = 4;

    // Reserved size reports 4 so the range check stays conservative.
    function automatic logic [2:0] bytes_of(input size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data memory: store byte enables and lane data,
// plus load extraction with sign/zero extension. Errors suppress both.
module dmem_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic        err,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt = {addr_lo, 3'b000};

    always_comb begin
        be     = 4'b0000;
        wlane  = wdata << shamt;
        rshift = rword >> shamt;
        rdata  = '0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                rdata = {{24{sgn & rshift[7]}}, rshift[7:0]};
            end
            SZ_HALF: begin
                be    = 4'b0011 << addr_lo;
                rdata = {{16{sgn & rshift[15]}}, rshift[15:0]};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                rdata = rword;
            end
            default: ;
        endcase
        if (err) begin
            be    = 4'b0000;
            rdata = '0;
        end
    end

endmodule

// File: rtl/data_memory_wait.sv
// Byte-addressable MEM-stage data memory with a programmable number of wait
// states; stalls the pipeline until a one-cycle ack completes each access.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no access pending; a request is latched when req_i is high
//   ST_WAIT | wait states counting down; pipeline held by stall_o
//   ST_DONE | access committed on entry; ack_o/err_o valid this cycle
module data_memory_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int DBG_ADDR    = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [7:0]  memory_o
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       mem [DEPTH_BYTES];

    logic             lat_we, lat_sgn, lat_err;
    size_e            lat_size;
    logic [AW-1:0]    lat_addr;
    logic [31:0]      lat_wdata;

    logic             idle, commit;
    logic             cur_we, cur_sgn, cur_err;
    size_e            cur_size, req_size;
    logic [AW-1:0]    cur_addr, base;
    logic [31:0]      cur_wdata, rword, wlane, ld_data;
    logic [3:0]       be;
    logic             req_err;
    logic [32:0]      req_last;

    assign idle     = (state == ST_IDLE);
    assign req_size = size_e'(size_i);

    // In IDLE the live request is used so a zero-wait access can commit
    // on the very edge that samples it.
    assign cur_we    = idle ? we_i              : lat_we;
    assign cur_sgn   = idle ? signed_i          : lat_sgn;
    assign cur_size  = idle ? req_size          : lat_size;
    assign cur_addr  = idle ? addr_i[AW-1:0]    : lat_addr;
    assign cur_wdata = idle ? wdata_i           : lat_wdata;
    assign cur_err   = idle ? req_err           : lat_err;

    // Full 32-bit range check with one extra bit so the end address cannot wrap.
    assign req_last = {1'b0, addr_i} + 33'(bytes_of(req_size)) - 33'd1;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_HALF: req_err = addr_i[0];
            SZ_WORD: req_err = (addr_i[1:0] != 2'b00);
            SZ_RSVD: req_err = 1'b1;
            default: ;
        endcase
        if (req_last >= 33'(DEPTH_BYTES)) begin
            req_err = 1'b1;
        end
    end

    assign base = cur_addr & ~AW'(3);

    always_comb begin
        rword = '0;
        for (int k = 0; k < 4; k++) begin
            rword[8*k +: 8] = mem[base | AW'(k)];
        end
    end

    dmem_align u_align (
        .size    (cur_size),
        .sgn     (cur_sgn),
        .addr_lo (cur_addr[1:0]),
        .err     (cur_err),
        .wdata   (cur_wdata),
        .rword   (rword),
        .be      (be),
        .wlane   (wlane),
        .rdata   (ld_data)
    );

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_DONE;
                        commit    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    commit    = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stall_o  = (idle && req_i) || (state == ST_WAIT);
    assign ack_o    = (state == ST_DONE);
    assign memory_o = mem[AW'(DBG_ADDR)];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_sgn   <= 1'b0;
            lat_err   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            state <= state_nxt;
            err_o <= commit & cur_err;
            if (idle && req_i) begin
                lat_we    <= we_i;
                lat_sgn   <= signed_i;
                lat_err   <= req_err;
                lat_size  <= req_size;
                lat_addr  <= addr_i[AW-1:0];
                lat_wdata <= wdata_i;
                cnt       <= CNT_INIT;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                if (cur_we) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) begin
                            mem[base | AW'(k)] <= wlane[8*k +: 8];
                        end
                    end
                end else begin
                    rdata_o <= ld_data;
                end
            end
        end
    end

endmodule
